// File: rtl/dmem_trace.sv
// rtl/dmem_trace.sv - single-cycle data memory with store trace FIFO
//
// Purpose: byte-lane data memory for the MEM stage with an asynchronous read
// port, plus a first-word fall-through FIFO recording every accepted store.
// Stores never stall; records arriving at a full FIFO are counted and dropped.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   daddr, dwdata, we store/read address, lane-aligned store data, lane enables
//   drdata            combinational read data (0 when out of range)
//   trace_valid/ready head handshake; trace_addr/data/be are the head record
//   trace_level       FIFO occupancy 0..FDEPTH
//   drop_cnt          saturating count of records lost to a full FIFO
//   oor_flag          sticky, set by any out-of-range store
module dmem_trace #(
    parameter int WORDS  = 32,
    parameter int FDEPTH = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               daddr,
    input  logic [31:0]               dwdata,
    input  logic [3:0]                we,
    output logic [31:0]               drdata,
    output logic                      trace_valid,
    output logic [31:0]               trace_addr,
    output logic [31:0]               trace_data,
    output logic [3:0]                trace_be,
    input  logic                      trace_ready,
    output logic [$clog2(FDEPTH):0]   trace_level,
    output logic [15:0]               drop_cnt,
    output logic                      oor_flag
);

    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int PW = $clog2(FDEPTH);
    localparam logic [31:0]   LAST_ADDR = 32'(4 * WORDS - 4);
    localparam logic [PW:0]   FULL_LVL  = (PW + 1)'(FDEPTH);

    logic [31:0] mem_q [WORDS];

    logic [31:0] fifo_addr_q [FDEPTH];
    logic [31:0] fifo_data_q [FDEPTH];
    logic [3:0]  fifo_be_q   [FDEPTH];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   level_q, level_d;
    logic [15:0]   drop_q, drop_d;
    logic          oor_q, oor_d;

    logic          in_range;
    logic [IW-1:0] idx;
    logic          store_req;
    logic          store_ok;
    logic          fifo_full;
    logic          pop;
    logic          push;
    logic          drop;

    // Address bits [1:0] only select a byte lane; the word index starts at bit 2.
    assign in_range  = (daddr <= LAST_ADDR);
    assign idx       = daddr[IW+1:2];
    assign store_req = (we != 4'b0000);
    assign store_ok  = store_req && in_range;

    assign fifo_full = (level_q == FULL_LVL);
    assign pop       = (level_q != '0) && trace_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign push      = store_ok && (!fifo_full || pop);
    assign drop      = store_ok && fifo_full && !pop;

    assign drdata      = in_range ? mem_q[idx] : 32'h0;
    assign trace_valid = (level_q != '0);
    assign trace_addr  = fifo_addr_q[head_q];
    assign trace_data  = fifo_data_q[head_q];
    assign trace_be    = fifo_be_q[head_q];
    assign trace_level = level_q;
    assign drop_cnt    = drop_q;
    assign oor_flag    = oor_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        level_d = level_q;
        drop_d  = drop_q;
        oor_d   = oor_q;
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push) begin
            tail_d = tail_q + 1'b1;
        end
        if (push && !pop) begin
            level_d = level_q + 1'b1;
        end else if (pop && !push) begin
            level_d = level_q - 1'b1;
        end
        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
        if (store_req && !in_range) begin
            oor_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WORDS; w++) begin
                mem_q[w] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            level_q <= '0;
            drop_q  <= '0;
            oor_q   <= 1'b0;
        end else begin
            if (store_ok) begin
                for (int l = 0; l < 4; l++) begin
                    if (we[l]) begin
                        mem_q[idx][8*l +: 8] <= dwdata[8*l +: 8];
                    end
                end
            end
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            drop_q  <= drop_d;
            oor_q   <= oor_d;
        end
    end

    // Payload storage needs no reset: it is only observed while trace_valid is 1.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo_addr_q[tail_q] <= daddr;
            fifo_data_q[tail_q] <= dwdata;
            fifo_be_q[tail_q]   <= we;
        end
    end

endmodule

// File: tb/tb_dmem_trace.sv
// tb/tb_dmem_trace.sv - directed self-checking bench for dmem_trace
module tb_dmem_trace;

    logic        clk;
    logic        rst;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [3:0]  we;
    logic [31:0] drdata;
    logic        trace_valid;
    logic [31:0] trace_addr;
    logic [31:0] trace_data;
    logic [3:0]  trace_be;
    logic        trace_ready;
    logic [3:0]  trace_level;
    logic [15:0] drop_cnt;
    logic        oor_flag;

    int vec_cnt = 0;
    int err_cnt = 0;

    dmem_trace #(.WORDS(32), .FDEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .daddr       (daddr),
        .dwdata      (dwdata),
        .we          (we),
        .drdata      (drdata),
        .trace_valid (trace_valid),
        .trace_addr  (trace_addr),
        .trace_data  (trace_data),
        .trace_be    (trace_be),
        .trace_ready (trace_ready),
        .trace_level (trace_level),
        .drop_cnt    (drop_cnt),
        .oor_flag    (oor_flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        daddr  = a;
        dwdata = d;
        we     = b;
        step();
        we     = 4'b0000;
        #1;
    endtask

    initial begin
        rst = 1'b1; daddr = '0; dwdata = '0; we = '0; trace_ready = 1'b0;
        step();
        rst = 1'b0;
        #1;

        // Reset read sweep
        for (int a = 0; a <= 'h7C; a += 4) begin
            daddr = 32'(a);
            #1;
            check($sformatf("rst_rd_%0h", a), drdata, 32'h0);
        end
        check("rst_valid", 32'(trace_valid), 32'h0);
        check("rst_level", 32'(trace_level), 32'h0);
        check("rst_drop", 32'(drop_cnt), 32'h0);
        check("rst_oor", 32'(oor_flag), 32'h0);

        // Byte lanes and read-during-write
        daddr = 32'h10; dwdata = 32'hDEADBEEF; we = 4'b1111;
        #1;
        check("bl_rdw0", drdata, 32'h0);
        step();
        check("bl_word", drdata, 32'hDEADBEEF);
        check("bl_valid_after", 32'(trace_valid), 32'h1);
        dwdata = 32'h00AA0000; we = 4'b0100;
        #1;
        check("bl_rdw1", drdata, 32'hDEADBEEF);
        step();
        we = 4'b0000;
        #1;
        check("bl_merge", drdata, 32'hDEAABEEF);
        check("bl_level", 32'(trace_level), 32'h2);
        check("bl_h0_addr", trace_addr, 32'h10);
        check("bl_h0_data", trace_data, 32'hDEADBEEF);
        check("bl_h0_be", 32'(trace_be), 32'hF);
        trace_ready = 1'b1;
        step();
        check("bl_h1_data", trace_data, 32'h00AA0000);
        check("bl_h1_be", 32'(trace_be), 32'h4);
        step();
        check("bl_empty", 32'(trace_valid), 32'h0);
        step();
        check("bl_empty_ready", 32'(trace_level), 32'h0);
        trace_ready = 1'b0;

        // Out of range
        store(32'h80, 32'h12345678, 4'b1111);
        daddr = 32'h80;
        #1;
        check("oor_flag", 32'(oor_flag), 32'h1);
        check("oor_level", 32'(trace_level), 32'h0);
        check("oor_rd", drdata, 32'h0);
        daddr = 32'h00;
        step(); step();
        check("oor_sticky", 32'(oor_flag), 32'h1);

        // Overflow: 10 stores into an 8-deep FIFO
        for (int i = 0; i < 10; i++) store(32'(4 * i), 32'(i), 4'b1111);
        check("ov_level", 32'(trace_level), 32'h8);
        check("ov_drop", 32'(drop_cnt), 32'h2);
        daddr = 32'h24;
        #1;
        check("ov_mem_last", drdata, 32'h9);
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("ov_v%0d", i), 32'(trace_valid), 32'h1);
            check($sformatf("ov_a%0d", i), trace_addr, 32'(4 * i));
            check($sformatf("ov_d%0d", i), trace_data, 32'(i));
            step();
        end
        check("ov_drained", 32'(trace_valid), 32'h0);
        trace_ready = 1'b0;

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) store(32'(4 * i), 32'h100 + 32'(i), 4'b1111);
        check("fp_full", 32'(trace_level), 32'h8);
        check("fp_head0", trace_addr, 32'h0);
        trace_ready = 1'b1;
        store(32'h40, 32'hABCD0040, 4'b1111);
        trace_ready = 1'b0;
        #1;
        check("fp_level", 32'(trace_level), 32'h8);
        check("fp_drop", 32'(drop_cnt), 32'h2);
        trace_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            check($sformatf("fp_a%0d", i), trace_addr, 32'(4 * i));
            step();
        end
        check("fp_wrap_addr", trace_addr, 32'h40);
        check("fp_wrap_data", trace_data, 32'hABCD0040);
        step();
        check("fp_empty", 32'(trace_valid), 32'h0);
        trace_ready = 1'b0;

        // Reset mid-traffic: level 5, drop 3
        for (int i = 0; i < 9; i++) store(32'(4 * i), 32'h200 + 32'(i), 4'b1111);
        trace_ready = 1'b1;
        step(); step(); step();
        trace_ready = 1'b0;
        #1;
        check("rm_pre_level", 32'(trace_level), 32'h5);
        check("rm_pre_drop", 32'(drop_cnt), 32'h3);
        rst = 1'b1;
        store(32'h08, 32'hCAFEF00D, 4'b1111);
        rst = 1'b0;
        daddr = 32'h08;
        #1;
        check("rm_level", 32'(trace_level), 32'h0);
        check("rm_drop", 32'(drop_cnt), 32'h0);
        check("rm_rd08", drdata, 32'h0);
        check("rm_valid", 32'(trace_valid), 32'h0);
        check("rm_oor", 32'(oor_flag), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
